// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, dispatch classes,
// opcode values and the select/strobe codes driven onto the datapath.
package cu_pkg;

  typedef enum logic [3:0] {
    S_START, S_IF1, S_IF2, S_DECODE, S_MEM1, S_MEM2,
    S_ST, S_INCR, S_JUMP, S_HALT, S_TRAP
  } state_t;

  // Where DECODE sends the FSM next; one class per successor state.
  typedef enum logic [2:0] {
    C_INCR, C_MEM, C_ST, C_JUMP, C_HALT, C_TRAP
  } class_t;

  localparam int unsigned OP_NOP   = 0;
  localparam int unsigned OP_LOAD  = 1;
  localparam int unsigned OP_STORE = 2;
  localparam int unsigned OP_ADD   = 3;
  localparam int unsigned OP_SUB   = 4;
  localparam int unsigned OP_JMP   = 5;
  localparam int unsigned OP_JZ    = 6;

  localparam logic MEM_READ    = 1'b1;
  localparam logic MEM_WRITE   = 1'b0;
  localparam logic MEM_ENABLE  = 1'b0;
  localparam logic MEM_DISABLE = 1'b1;

  localparam logic [1:0] DBUS_MEM = 2'b00;
  localparam logic [1:0] DBUS_GPR = 2'b01;
  localparam logic [1:0] DBUS_ALU = 2'b10;

  localparam logic [1:0] ABUS_IP  = 2'b00;
  localparam logic [1:0] ABUS_CU  = 2'b01;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode dispatch: opcode + zero_flag -> next-state class and ALU op.
// CU_ILLEGAL_TRAP_EN selects trapping on undefined opcodes instead of treating them as NOP.
module cu_decode
  import cu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic           zero_flag,
  output class_t         cls,
  output logic [1:0]     alu
);

  always_comb begin
    cls = C_INCR;
    alu = ALU_PASS;
    // All-ones is HALT regardless of width, so it is tested before the table.
    if (&opcode) begin
      cls = C_HALT;
    end else begin
      case (opcode)
        OPW'(OP_NOP):   cls = C_INCR;
        OPW'(OP_LOAD):  cls = C_MEM;
        OPW'(OP_STORE): cls = C_ST;
        OPW'(OP_ADD): begin
          cls = C_MEM;
          alu = ALU_ADD;
        end
        OPW'(OP_SUB): begin
          cls = C_MEM;
          alu = ALU_SUB;
        end
        OPW'(OP_JMP):   cls = C_JUMP;
        OPW'(OP_JZ):    cls = zero_flag ? C_JUMP : C_INCR;
`ifdef CU_ILLEGAL_TRAP_EN
        default:        cls = C_TRAP;
`else
        default:        cls = C_INCR;
`endif
      endcase
    end
  end

endmodule

// File: rtl/cu_multicycle.sv
// Multicycle control unit: fetch/decode/execute FSM with mem_ready wait states.
// Defining CU_ILLEGAL_TRAP_EN adds the TRAP state and the illegal_op output.
module cu_multicycle
  import cu_pkg::*;
#(
  parameter int OPW = 4,
  parameter int RAW = 4,
  parameter int AW  = 8,
  localparam int IW = OPW + RAW + AW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IW-1:0]  ir_data,
  input  logic           mem_ready,
  input  logic           zero_flag,
  output logic [1:0]     data_select,
  output logic [1:0]     address_select,
  output logic           sram_en,
  output logic           write_en,
  output logic           ir_load,
  output logic           gpr_load,
  output logic           ip_increment,
  output logic           ip_load,
  output logic [1:0]     alu_op,
  output logic [RAW-1:0] ra,
  output logic [AW-1:0]  address,
  output logic           reset_internal,
  output logic           halted
`ifdef CU_ILLEGAL_TRAP_EN
  ,
  output logic           illegal_op
`endif
);

  state_t     state, next;
  class_t     cls;
  logic [1:0] dec_alu;
  logic [1:0] alu_sel;

  cu_decode #(.OPW(OPW)) u_decode (
    .opcode    (ir_data[IW-1 -: OPW]),
    .zero_flag (zero_flag),
    .cls       (cls),
    .alu       (dec_alu)
  );

  // Fields are captured on leaving DECODE so MEM/ST/JUMP see a stable address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_START;
      ra      <= '0;
      address <= '0;
      alu_sel <= ALU_PASS;
    end else begin
      state <= next;
      if (state == S_DECODE) begin
        ra      <= ir_data[AW +: RAW];
        address <= ir_data[AW-1:0];
        alu_sel <= dec_alu;
      end
    end
  end

  always_comb begin
    next           = state;
    data_select    = DBUS_MEM;
    address_select = ABUS_IP;
    sram_en        = MEM_DISABLE;
    write_en       = MEM_READ;
    ir_load        = 1'b0;
    gpr_load       = 1'b0;
    ip_increment   = 1'b0;
    ip_load        = 1'b0;
    alu_op         = ALU_PASS;
    reset_internal = 1'b1;
    halted         = 1'b0;
    case (state)
      S_START: begin
        reset_internal = 1'b0;
        next           = S_IF1;
      end
      S_IF1: begin
        sram_en = MEM_ENABLE;
        if (mem_ready) next = S_IF2;
      end
      S_IF2: begin
        ir_load = 1'b1;
        next    = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          C_MEM:   next = S_MEM1;
          C_ST:    next = S_ST;
          C_JUMP:  next = S_JUMP;
          C_HALT:  next = S_HALT;
          C_TRAP:  next = S_TRAP;
          default: next = S_INCR;
        endcase
      end
      S_MEM1: begin
        address_select = ABUS_CU;
        sram_en        = MEM_ENABLE;
        if (mem_ready) next = S_MEM2;
      end
      S_MEM2: begin
        gpr_load    = 1'b1;
        alu_op      = alu_sel;
        data_select = (alu_sel == ALU_PASS) ? DBUS_MEM : DBUS_ALU;
        next        = S_INCR;
      end
      S_ST: begin
        data_select    = DBUS_GPR;
        address_select = ABUS_CU;
        write_en       = MEM_WRITE;
        sram_en        = MEM_ENABLE;
        if (mem_ready) next = S_INCR;
      end
      S_INCR: begin
        ip_increment = 1'b1;
        next         = S_IF1;
      end
      S_JUMP: begin
        ip_load = 1'b1;
        next    = S_IF1;
      end
      S_HALT:  halted = 1'b1;
      S_TRAP:  halted = 1'b1;
      default: next = S_START;
    endcase
  end

`ifdef CU_ILLEGAL_TRAP_EN
  assign illegal_op = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_cu_multicycle.sv
// Directed table-driven bench for cu_multicycle plus a wide-field instance (OPW=6, RAW=5, AW=16).
module tb_cu_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] ir_data = '0;
  logic        mem_ready = 1'b1;
  logic        zero_flag = 1'b0;
  logic [1:0]  data_select, address_select, alu_op;
  logic        sram_en, write_en, ir_load, gpr_load, ip_increment, ip_load;
  logic [3:0]  ra;
  logic [7:0]  address;
  logic        reset_internal, halted;

  logic [26:0] ir_w = {6'h03, 5'h1B, 16'hBEEF};
  logic [1:0]  data_select_w, address_select_w, alu_op_w;
  logic        sram_en_w, write_en_w, ir_load_w, gpr_load_w, ip_increment_w, ip_load_w;
  logic [4:0]  ra_w;
  logic [15:0] address_w;
  logic        reset_internal_w, halted_w;
`ifdef CU_ILLEGAL_TRAP_EN
  logic        illegal_op, illegal_op_w;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cu_multicycle dut (
    .clk(clk), .reset(reset), .ir_data(ir_data), .mem_ready(mem_ready), .zero_flag(zero_flag),
    .data_select(data_select), .address_select(address_select), .sram_en(sram_en),
    .write_en(write_en), .ir_load(ir_load), .gpr_load(gpr_load), .ip_increment(ip_increment),
    .ip_load(ip_load), .alu_op(alu_op), .ra(ra), .address(address),
    .reset_internal(reset_internal), .halted(halted)
`ifdef CU_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  cu_multicycle #(.OPW(6), .RAW(5), .AW(16)) dut_w (
    .clk(clk), .reset(reset), .ir_data(ir_w), .mem_ready(mem_ready), .zero_flag(zero_flag),
    .data_select(data_select_w), .address_select(address_select_w), .sram_en(sram_en_w),
    .write_en(write_en_w), .ir_load(ir_load_w), .gpr_load(gpr_load_w),
    .ip_increment(ip_increment_w), .ip_load(ip_load_w), .alu_op(alu_op_w), .ra(ra_w),
    .address(address_w), .reset_internal(reset_internal_w), .halted(halted_w)
`ifdef CU_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op_w)
`endif
  );

  // {data_select, address_select, sram_en, write_en, ir_load, gpr_load,
  //  ip_increment, ip_load, alu_op, halted, reset_internal}
  logic [13:0] obs;
  assign obs = {data_select, address_select, sram_en, write_en, ir_load, gpr_load,
                ip_increment, ip_load, alu_op, halted, reset_internal};

  localparam logic [13:0] E_START = {2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
  localparam logic [13:0] E_IF1   = {2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
  localparam logic [13:0] E_IF2   = {2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
  localparam logic [13:0] E_DEC   = {2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
  localparam logic [13:0] E_MEM1  = {2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
  localparam logic [13:0] E_MLD   = {2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
  localparam logic [13:0] E_MADD  = {2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1};
  localparam logic [13:0] E_MSUB  = {2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1};
  localparam logic [13:0] E_ST    = {2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
  localparam logic [13:0] E_INCR  = {2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1};
  localparam logic [13:0] E_JUMP  = {2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
  localparam logic [13:0] E_HALT  = {2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1};

  localparam logic [15:0] I_LD  = 16'h1110;
  localparam logic [15:0] I_ADD = 16'h3111;
  localparam logic [15:0] I_ST  = 16'h2112;
  localparam logic [15:0] I_HLT = 16'hF000;
  localparam logic [15:0] I_NOP = 16'h0000;
  localparam logic [15:0] I_ST5 = 16'h2512;
  localparam logic [15:0] I_JZ  = 16'h6040;
  localparam logic [15:0] I_SUB = 16'h4220;
  localparam logic [15:0] I_JMP = 16'h5033;
  localparam logic [15:0] I_ILL = 16'h7000;

  typedef struct {
    logic        mr;
    logic        zf;
    logic [15:0] ir;
    logic [13:0] exp;
    logic        chk_f;
    logic [3:0]  ra;
    logic [7:0]  addr;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic add(input logic mr, input logic zf, input logic [15:0] ir,
                     input logic [13:0] exp, input string nm);
    vec_t v;
    v.mr = mr; v.zf = zf; v.ir = ir; v.exp = exp; v.chk_f = 1'b0;
    v.ra = '0; v.addr = '0; v.name = nm;
    tbl.push_back(v);
  endtask

  task automatic addf(input logic mr, input logic [15:0] ir, input logic [13:0] exp,
                      input logic [3:0] r, input logic [7:0] a, input string nm);
    vec_t v;
    v.mr = mr; v.zf = 1'b0; v.ir = ir; v.exp = exp; v.chk_f = 1'b1;
    v.ra = r; v.addr = a; v.name = nm;
    tbl.push_back(v);
  endtask

  // Called at a negedge; each row sets this cycle's inputs and checks this cycle's outputs.
  task automatic run_tbl();
    for (int i = 0; i < tbl.size(); i++) begin
      mem_ready = tbl[i].mr;
      zero_flag = tbl[i].zf;
      ir_data   = tbl[i].ir;
      #1;
      chk($sformatf("%s[%0d]", tbl[i].name, i), 32'(obs), 32'(tbl[i].exp));
      if (tbl[i].chk_f) begin
        chk($sformatf("%s[%0d].ra", tbl[i].name, i), 32'(ra), 32'(tbl[i].ra));
        chk($sformatf("%s[%0d].addr", tbl[i].name, i), 32'(address), 32'(tbl[i].addr));
      end
      @(negedge clk);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    zero_flag = 1'b0;
    @(negedge clk);
    #1;
    chk("reset.outputs", 32'(obs), 32'(E_START));
    chk("reset.ra_addr", {20'd0, ra, address}, 32'd0);
    chk("reset.wide_addr", 32'(address_w), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((ip_increment && ip_load) || (gpr_load && !sram_en && !write_en)) begin
        errors++;
        $display("FAIL exclusive_strobes: ip_inc=%b ip_load=%b gpr_load=%b sram_en=%b write_en=%b",
                 ip_increment, ip_load, gpr_load, sram_en, write_en);
      end
    end
  end

  initial begin
    #2 reset = 1'b1;

    // Program: LOAD r1,0x10; ADD r1,0x11; STORE r1,0x12; HALT
    do_reset();
    add(1, 0, I_LD, E_START, "prog.start");
    add(1, 0, I_LD, E_IF1, "ld.if1");   add(1, 0, I_LD, E_IF2, "ld.if2");
    add(1, 0, I_LD, E_DEC, "ld.dec");   addf(1, I_LD, E_MEM1, 4'h1, 8'h10, "ld.mem1");
    add(1, 0, I_LD, E_MLD, "ld.mem2");  add(1, 0, I_LD, E_INCR, "ld.incr");
    add(1, 0, I_ADD, E_IF1, "add.if1"); add(1, 0, I_ADD, E_IF2, "add.if2");
    add(1, 0, I_ADD, E_DEC, "add.dec"); addf(1, I_ADD, E_MEM1, 4'h1, 8'h11, "add.mem1");
    add(1, 0, I_ADD, E_MADD, "add.mem2"); add(1, 0, I_ADD, E_INCR, "add.incr");
    add(1, 0, I_ST, E_IF1, "st.if1");   add(1, 0, I_ST, E_IF2, "st.if2");
    add(1, 0, I_ST, E_DEC, "st.dec");   addf(1, I_ST, E_ST, 4'h1, 8'h12, "st.st");
    add(1, 0, I_ST, E_INCR, "st.incr");
    add(1, 0, I_HLT, E_IF1, "hlt.if1"); add(1, 0, I_HLT, E_IF2, "hlt.if2");
    add(1, 0, I_HLT, E_DEC, "hlt.dec");
    for (int k = 0; k < 3; k++) add(1, 0, I_HLT, E_HALT, "hlt.halt");
    run_tbl();

    // Wait states in IF1 and ST
    do_reset();
    add(1, 0, I_NOP, E_START, "ws.start");
    for (int k = 0; k < 3; k++) add(0, 0, I_NOP, E_IF1, "ws.if1_wait");
    add(1, 0, I_NOP, E_IF1, "ws.if1_go"); add(1, 0, I_NOP, E_IF2, "ws.if2");
    add(1, 0, I_NOP, E_DEC, "nop.dec");   add(1, 0, I_NOP, E_INCR, "nop.incr");
    add(1, 0, I_ST5, E_IF1, "ws.st.if1"); add(1, 0, I_ST5, E_IF2, "ws.st.if2");
    add(1, 0, I_ST5, E_DEC, "ws.st.dec");
    for (int k = 0; k < 3; k++) addf(0, I_ST5, E_ST, 4'h5, 8'h12, "ws.st_wait");
    addf(1, I_ST5, E_ST, 4'h5, 8'h12, "ws.st_go");
    add(1, 0, I_ST5, E_INCR, "ws.st.incr"); add(1, 0, I_NOP, E_IF1, "ws.next_if1");
    run_tbl();

    // JZ taken / not taken, SUB, JMP
    do_reset();
    add(1, 0, I_JZ, E_START, "jz.start");
    add(1, 0, I_JZ, E_IF1, "jz1.if1"); add(1, 0, I_JZ, E_IF2, "jz1.if2");
    add(1, 1, I_JZ, E_DEC, "jz1.dec"); addf(1, I_JZ, E_JUMP, 4'h0, 8'h40, "jz1.jump");
    add(1, 0, I_JZ, E_IF1, "jz0.if1"); add(1, 0, I_JZ, E_IF2, "jz0.if2");
    add(1, 0, I_JZ, E_DEC, "jz0.dec"); add(1, 0, I_JZ, E_INCR, "jz0.incr");
    add(1, 0, I_SUB, E_IF1, "sub.if1"); add(1, 0, I_SUB, E_IF2, "sub.if2");
    add(1, 0, I_SUB, E_DEC, "sub.dec"); addf(1, I_SUB, E_MEM1, 4'h2, 8'h20, "sub.mem1");
    add(1, 0, I_SUB, E_MSUB, "sub.mem2"); add(1, 0, I_SUB, E_INCR, "sub.incr");
    add(1, 0, I_JMP, E_IF1, "jmp.if1"); add(1, 0, I_JMP, E_IF2, "jmp.if2");
    add(1, 0, I_JMP, E_DEC, "jmp.dec"); addf(1, I_JMP, E_JUMP, 4'h0, 8'h33, "jmp.jump");
    add(1, 0, I_NOP, E_IF1, "jmp.next_if1");
    run_tbl();

    // Undefined opcode 0111
    do_reset();
    add(1, 0, I_ILL, E_START, "ill.start");
    add(1, 0, I_ILL, E_IF1, "ill.if1"); add(1, 0, I_ILL, E_IF2, "ill.if2");
    add(1, 0, I_ILL, E_DEC, "ill.dec");
`ifdef CU_ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) add(1, 0, I_NOP, E_HALT, "ill.trap");
    run_tbl();
    chk("ill.illegal_op_set", 32'(illegal_op), 32'd1);
    do_reset();
    chk("ill.illegal_op_clr", 32'(illegal_op), 32'd0);
`else
    add(1, 0, I_ILL, E_INCR, "ill.as_nop"); add(1, 0, I_NOP, E_IF1, "ill.next_if1");
    run_tbl();
`endif

    // Async reset in the middle of a held STORE
    do_reset();
    add(1, 0, I_ST, E_START, "rst.start");
    add(1, 0, I_ST, E_IF1, "rst.if1"); add(1, 0, I_ST, E_IF2, "rst.if2");
    add(1, 0, I_ST, E_DEC, "rst.dec"); add(0, 0, I_ST, E_ST, "rst.st_held");
    run_tbl();
    #2 reset = 1'b1;
    #1;
    chk("rst.mid_store.sram_en", 32'(sram_en), 32'd1);
    chk("rst.mid_store.write_en", 32'(write_en), 32'd1);
    chk("rst.mid_store.outputs", 32'(obs), 32'(E_START));
    @(negedge clk);
    reset = 1'b0;

    // Wide build: fields of a 27-bit instruction
    do_reset();
    repeat (4) @(negedge clk);
    #1;
    chk("wide.address", 32'(address_w), 32'h0000BEEF);
    chk("wide.ra", 32'(ra_w), 32'h1B);
    chk("wide.addr_sel", 32'(address_select_w), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
